// File: rtl/memory_cycle.sv
// EX/MEM stage: registers the execute result, runs loads/stores over a req/gnt/rvalid
// data-memory handshake and presents one-cycle-valid results to writeback.
module memory_cycle #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned REG_ADDR_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [XLEN-1:0]          ex_alu_result,
  input  logic [XLEN-1:0]          ex_store_data,
  input  logic [REG_ADDR_SIZE-1:0] ex_rd,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic                     ex_mem_write,
  input  logic [2:0]               ex_funct3,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [XLEN-1:0]          dmem_addr,
  output logic [XLEN-1:0]          dmem_wdata,
  output logic [3:0]               dmem_wstrb,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [XLEN-1:0]          dmem_rdata,
  output logic                     wb_valid,
  output logic [REG_ADDR_SIZE-1:0] wb_rd,
  output logic                     wb_reg_write,
  output logic [XLEN-1:0]          wb_data,
  output logic                     wb_fault
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [XLEN-1:0]          addr_q, wdata_q;
  logic [3:0]               wstrb_q;
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [REG_ADDR_SIZE-1:0] rd_q;
  logic                     reg_write_q;

  logic                     wb_valid_q, wb_reg_write_q, wb_fault_q;
  logic [REG_ADDR_SIZE-1:0] wb_rd_q;
  logic [XLEN-1:0]          wb_data_q;

  logic            accept, is_mem, misaligned, illegal, fault, start_mem;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign accept    = ex_valid && (state_q == IDLE);
  assign is_mem    = ex_mem_read | ex_mem_write;
  assign start_mem = accept && is_mem && !fault;

  always_comb begin
    case (ex_funct3[1:0])
      2'b01:   misaligned = ex_alu_result[0];
      2'b10:   misaligned = |ex_alu_result[1:0];
      default: misaligned = 1'b0;
    endcase
    if (ex_mem_read) begin
      illegal = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
    end else begin
      illegal = (ex_funct3 > 3'b010);
    end
    fault = is_mem && (misaligned || illegal);
  end

  // Sub-word stores replicate the lane so memory only needs the strobes.
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << ex_alu_result[1:0];
        st_wdata = XLEN'({4{ex_store_data[7:0]}});
      end
      2'b01: begin
        st_strb  = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = XLEN'({2{ex_store_data[15:0]}});
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_mem) state_d = REQ;
      REQ:     if (dmem_gnt) state_d = we_q ? IDLE : WAIT_RD;
      WAIT_RD: if (dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields only change on a new access so they stay stable until gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (start_mem) begin
      addr_q      <= ex_alu_result;
      wdata_q     <= ex_mem_write ? st_wdata : '0;
      wstrb_q     <= ex_mem_write ? st_strb : 4'b0000;
      we_q        <= ex_mem_write;
      funct3_q    <= ex_funct3;
      rd_q        <= ex_rd;
      reg_write_q <= ex_reg_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      wb_fault_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && (!is_mem || fault)) begin
            wb_valid_q     <= 1'b1;
            wb_rd_q        <= ex_rd;
            wb_reg_write_q <= is_mem ? 1'b0 : ex_reg_write;
            wb_data_q      <= ex_alu_result;
            wb_fault_q     <= fault;
          end
        end
        REQ: begin
          if (dmem_gnt && we_q) begin
            wb_valid_q     <= 1'b1;
            wb_rd_q        <= rd_q;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= addr_q;
            wb_fault_q     <= 1'b0;
          end
        end
        WAIT_RD: begin
          if (dmem_rvalid) begin
            wb_valid_q     <= 1'b1;
            wb_rd_q        <= rd_q;
            wb_reg_write_q <= reg_write_q;
            wb_data_q      <= ld_data;
            wb_fault_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem_req     = (state_q == REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_data      = wb_data_q;
  assign wb_fault     = wb_fault_q;

endmodule
